// File: rtl/video_scanout_if.sv
// video_scanout_if
//   Read-port bundle between the raster scan-out stage and the video RAM.
//   Ports / members:
//     readEn       scan-out -> RAM  read enable, high for visible pixels
//     readPointer  scan-out -> RAM  linear pixel address (ADDR_W bits)
//     ramData      RAM -> scan-out  pixel word (DATA_W bits)
//   Modports: master = scan-out side, slave = RAM side.
interface video_scanout_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 24
);
  logic              readEn;
  logic [ADDR_W-1:0] readPointer;
  logic [DATA_W-1:0] ramData;

  modport master (output readEn, output readPointer, input ramData);
  modport slave  (input readEn, input readPointer, output ramData);
endinterface

// File: rtl/video_scanout.sv
// video_scanout
//   Raster scan-out stage sitting directly behind the video RAM. Generates
//   horizontal/vertical timing, drives the RAM read port with a linear pixel
//   address (frame base + pixel index), re-aligns de/hsync/vsync/frameStart
//   with the RAM read latency and emits registered RGB plus sync.
//   Ports:
//     clk         pixel clock
//     rst         synchronous, active-high reset
//     frameBase   start address of the next frame's buffer (latched per frame)
//     ram         RAM read port (readEn, readPointer out; ramData in)
//     rgbOut      {R,G,B} pixel, black outside the visible region
//     de          data enable, high for visible pixels
//     hsync/vsync sync outputs, active level set by HSYNC_POL/VSYNC_POL
//     frameStart  one-cycle pulse with the output of pixel (0,0)
module video_scanout #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   RAM_LATENCY = 1,
  parameter int   ADDR_W      = 20,
  parameter int   DATA_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   frameBase,
  video_scanout_if.master     ram,
  output logic [DATA_W-1:0]   rgbOut,
  output logic                de,
  output logic                hsync,
  output logic                vsync,
  output logic                frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Per-pixel control bits carried alongside the RAM access (active-high).
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  logic [HW-1:0]     h_reg, h_next;
  logic [VW-1:0]     v_reg, v_next;
  logic [ADDR_W-1:0] pix_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              read_en_reg;
  logic [ADDR_W-1:0] read_ptr_reg;
  logic              line_end, frame_end;
  logic              visible, hs_act, vs_act, first_pix;
  ctl_t              ctl_now;
  ctl_t              pipe_reg [0:RAM_LATENCY];

  // Timing decode from the current counter position.
  always_comb begin
    line_end  = (int'(h_reg) == H_TOTAL - 1);
    frame_end = line_end && (int'(v_reg) == V_TOTAL - 1);
    visible   = (int'(h_reg) < H_ACTIVE) && (int'(v_reg) < V_ACTIVE);
    hs_act    = (int'(h_reg) >= H_ACTIVE + H_FP) &&
                (int'(h_reg) <  H_ACTIVE + H_FP + H_SYNC);
    vs_act    = (int'(v_reg) >= V_ACTIVE + V_FP) &&
                (int'(v_reg) <  V_ACTIVE + V_FP + V_SYNC);
    first_pix = (h_reg == '0) && (v_reg == '0);
  end

  always_comb begin
    h_next = h_reg + HW'(1);
    v_next = v_reg;
    if (line_end) begin
      h_next = '0;
      v_next = frame_end ? '0 : v_reg + VW'(1);
    end
  end

  assign ctl_now = '{de: visible, hs: hs_act, vs: vs_act, fs: first_pix};

  // Counters, pixel index and RAM read port. base_reg only changes at the
  // frame wrap (or in reset), so a new frameBase never tears the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg        <= '0;
      v_reg        <= '0;
      pix_reg      <= '0;
      base_reg     <= frameBase;
      read_en_reg  <= 1'b0;
      read_ptr_reg <= '0;
    end else begin
      h_reg       <= h_next;
      v_reg       <= v_next;
      read_en_reg <= visible;
      // Address wraps modulo 2^ADDR_W; it holds while blanking.
      if (visible) begin
        read_ptr_reg <= base_reg + pix_reg;
      end
      if (frame_end) begin
        pix_reg  <= '0;
        base_reg <= frameBase;
      end else if (visible) begin
        pix_reg <= pix_reg + ADDR_W'(1);
      end
    end
  end

  assign ram.readEn      = read_en_reg;
  assign ram.readPointer = read_ptr_reg;

  // Control delay line: stage 0 is aligned with readEn, stage RAM_LATENCY
  // with ramData, so the output registers line up control with data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RAM_LATENCY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg[0] <= ctl_now;
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgbOut     <= '0;
      de         <= 1'b0;
      hsync      <= ~HSYNC_POL;
      vsync      <= ~VSYNC_POL;
      frameStart <= 1'b0;
    end else begin
      de         <= pipe_reg[RAM_LATENCY].de;
      // Blanking is forced black whatever the RAM returns.
      rgbOut     <= pipe_reg[RAM_LATENCY].de ? ram.ramData : '0;
      hsync      <= pipe_reg[RAM_LATENCY].hs ? HSYNC_POL : ~HSYNC_POL;
      vsync      <= pipe_reg[RAM_LATENCY].vs ? VSYNC_POL : ~VSYNC_POL;
      frameStart <= pipe_reg[RAM_LATENCY].fs;
    end
  end

endmodule
